fft_out_reorder: RTL
====================

# fft_out_reorder

Output reorder buffer for the parallel-4 FFT datapath. It accepts the four complex lanes the FFT produces each clock in bit-reversed bin order and re-emits each N-point frame in natural bin order, four bins per clock. It uses a ping-pong register bank, so one frame can be read out while the next is written. It sits between the last FFT quantiser stage and any downstream consumer.

## Interface
- NBITS_out, 21, width of each real and imaginary part. Lane word is {re, im}: re in [2*NBITS_out-1:NBITS_out], im in [NBITS_out-1:0].
- N, 128, FFT points per frame. Must be a power of 2 and at least 8. Beats per frame: BEATS = N/4.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- fftIn0_up, fftIn0_down, fftIn1_up, fftIn1_down  in  2*NBITS_out each  input lanes 0..3.
- in_valid  in  1  input beat present.
- in_sof  in  1  marks beat 0 of a frame. Qualified by in_valid.
- in_ready  out  1  buffer can accept a beat.
- fftOut0_up, fftOut0_down, fftOut1_up, fftOut1_down  out  2*NBITS_out each  output lanes 0..3.
- out_valid  out  1  output beat present.
- out_sof, out_eof  out  1  first and last output beat of a frame.
- out_ready  in  1  downstream accepts the beat.
- err_cnt  out  8  aborted-frame count. See Configuration.

## Operation
- Beat transfer:
  - An input beat transfers when in_valid && in_ready.
  - An output beat transfers when out_valid && out_ready.
- Input mapping:
  - Input beat c (0..BEATS-1), lane l (0..3) carries bin bitrev_log2N(4c+l).
  - The buffer writes that bin to that address in the write bank.
- Output mapping: output beat c, lane l carries bin 4c+l. Data passes through unmodified (no rounding, no saturation).
- Storage and state:
  - Two banks, each N × 2*NBITS_out flops.
  - State: wr_bank, rd_bank, full[1:0], wr_cnt and rd_cnt (each log2(BEATS) bits).
  - in_ready = !full[wr_bank].
- Write side:
  - An accepted beat with in_sof writes as beat 0. If wr_cnt != 0 at that moment, the partial frame is aborted: its data is discarded and err_cnt increments.
  - An accepted beat with !in_sof and wr_cnt == 0 is dropped. This is sync hunt: nothing is written and the beat is still acknowledged.
  - Otherwise the beat writes at wr_cnt, and wr_cnt increments.
  - When beat BEATS-1 is written: full[wr_bank] is set, wr_bank toggles, and wr_cnt returns to 0.
- Read side:
  - While full[rd_bank], the output register loads beat rd_cnt when it is empty or is transferring.
  - out_sof = (rd_cnt == 0) and out_eof = (rd_cnt == BEATS-1) for the beat loaded.
  - After beat BEATS-1 is loaded: full[rd_bank] clears, rd_bank toggles, and rd_cnt returns to 0.
- Simultaneous events:
  - The write completing and the read freeing a bank in the same cycle are independent. Both updates take effect.
  - Writing into the bank being freed is allowed from the next cycle.
- Output hold: output data and flags remain stable while out_valid && !out_ready.

## Timing
- Reset (rst low) drives all of the following immediately: outputs 0, out_valid 0, full 0, counters 0, banks select 0, err_cnt 0.
  - in_ready reads 1 after reset.
  - Bank contents are not reset.
- Latency: last input beat accepted in cycle n -> out_valid high with beat 0 in cycle n+2.
- Throughput: one beat per clock in and out, sustained, when out_ready is held high.
- Backpressure: with both banks full, in_ready is 0 until the output register loads the final beat of the read bank. in_ready returns high the cycle after.
- Reset mid-frame discards all partial and buffered frames without emitting them.

## Configuration
- FFT_REORDER_ERRCNT_EN defined: err_cnt is an 8-bit counter of aborted frames. It saturates at 255.
- FFT_REORDER_ERRCNT_EN undefined: err_cnt is tied to 0 and the counter logic is absent. Abort behaviour is otherwise identical.

## Structure
- Shared package fft_pkg holds:
  - the bitrev function parameterised by width;
  - the lane-word field offsets.
- One sub-module, fft_reorder_bank: a single N-entry register bank with one write port of 4 entries and one read port of 4 entries. It is instantiated twice.

## Test plan
- Reset, then one frame where each lane value is its own bin index (im = ~bin), with out_ready=1 -> 32 output beats; beat c lanes = bins 4c..4c+3; out_sof on beat 0, out_eof on beat 31; first out_valid 2 cycles after the last input.
- Three back-to-back frames with out_ready=1 -> continuous output with no gaps; in_ready stays 1.
- out_ready=0 during three input frames -> in_ready drops after 64 beats; each output beat holds until out_ready rises; no data loss.
- in_sof reasserted at beat 10 -> partial frame discarded; err_cnt = 1 (0 without the macro); the new frame is output correctly.
- 5 beats with in_sof=0 before the first sof -> beats dropped, in_ready=1 throughout; the frame is output correctly.
- rst pulsed low mid-readout -> out_valid=0 immediately; next frame correct.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output path: lane-word field layout and the
// bit-reversal used to map bit-reversed FFT bins onto natural-order addresses.
package fft_pkg;

  localparam int LANES  = 4;
  localparam int IM_LSB = 0;

  // The real part sits directly above the imaginary part.
  function automatic int re_lsb(input int nbits);
    return nbits;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] val, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) r[width-1-i] = val[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One N-entry frame bank: four scattered writes per clock, four consecutive
// entries (one output beat) read combinationally.
module fft_reorder_bank
  import fft_pkg::*;
#(
  parameter int W = 42,
  parameter int N = 128
) (
  input  logic                             clk,
  input  logic                             we,
  input  logic [LANES-1:0][$clog2(N)-1:0]  wr_addr,
  input  logic [LANES-1:0][W-1:0]          wr_data,
  input  logic [$clog2(N)-3:0]             rd_beat,
  output logic [LANES-1:0][W-1:0]          rd_data
);

  logic [W-1:0] mem [N];

  // Contents are deliberately left unreset; full flags gate every read.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < LANES; l++) begin
        mem[wr_addr[l]] <= wr_data[l];
      end
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_rd
    assign rd_data[gi] = mem[{rd_beat, 2'(gi)}];
  end

endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: bit-reversed 4-lane FFT beats in, natural order out.
// Define FFT_REORDER_ERRCNT_EN to build the saturating aborted-frame counter.
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int NBITS_out = 21,
  parameter int N         = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*NBITS_out-1:0] fftIn0_up,
  input  logic [2*NBITS_out-1:0] fftIn0_down,
  input  logic [2*NBITS_out-1:0] fftIn1_up,
  input  logic [2*NBITS_out-1:0] fftIn1_down,
  input  logic                   in_valid,
  input  logic                   in_sof,
  output logic                   in_ready,
  output logic [2*NBITS_out-1:0] fftOut0_up,
  output logic [2*NBITS_out-1:0] fftOut0_down,
  output logic [2*NBITS_out-1:0] fftOut1_up,
  output logic [2*NBITS_out-1:0] fftOut1_down,
  output logic                   out_valid,
  output logic                   out_sof,
  output logic                   out_eof,
  input  logic                   out_ready,
  output logic [7:0]             err_cnt
);

  localparam int W    = 2 * NBITS_out;
  localparam int LOGN = $clog2(N);
  localparam int CW   = LOGN - 2;
  localparam logic [CW-1:0] LAST = CW'(N / 4 - 1);

  logic                         wr_bank, rd_bank;
  logic [1:0]                   full;
  logic [CW-1:0]                wr_cnt, rd_cnt, wr_beat;
  logic [LANES-1:0][W-1:0]      in_lanes, out_lanes;
  logic [LANES-1:0][LOGN-1:0]   wr_addr;
  logic [1:0][LANES-1:0][W-1:0] bank_rd;
  logic                         accept, wr_en, load;

  assign in_lanes = {fftIn1_down, fftIn1_up, fftIn0_down, fftIn0_up};
  assign in_ready = !full[wr_bank];
  assign accept   = in_valid && in_ready;
  // A sof beat restarts the frame; a non-sof beat while hunting is acked but dropped.
  assign wr_beat  = in_sof ? '0 : wr_cnt;
  assign wr_en    = accept && (in_sof || wr_cnt != '0);
  assign load     = full[rd_bank] && (!out_valid || out_ready);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_waddr
    assign wr_addr[gi] = LOGN'(bitrev(32'({wr_beat, 2'(gi)}), LOGN));
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    fft_reorder_bank #(.W(W), .N(N)) u_bank (
      .clk     (clk),
      .we      (wr_en && (wr_bank == 1'(gi))),
      .wr_addr (wr_addr),
      .wr_data (in_lanes),
      .rd_beat (rd_cnt),
      .rd_data (bank_rd[gi])
    );
  end

  // Write completion and read release always touch different banks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= '0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      out_lanes <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      if (wr_en) begin
        if (wr_beat == LAST) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_cnt        <= '0;
        end else begin
          wr_cnt <= wr_beat + CW'(1);
        end
      end
      if (load) begin
        out_lanes <= bank_rd[rd_bank];
        out_valid <= 1'b1;
        out_sof   <= (rd_cnt == '0);
        out_eof   <= (rd_cnt == LAST);
        if (rd_cnt == LAST) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
          rd_cnt        <= '0;
        end else begin
          rd_cnt <= rd_cnt + CW'(1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign fftOut0_up   = out_lanes[0];
  assign fftOut0_down = out_lanes[1];
  assign fftOut1_up   = out_lanes[2];
  assign fftOut1_down = out_lanes[3];

`ifdef FFT_REORDER_ERRCNT_EN
  logic sof_abort;
  assign sof_abort = accept && in_sof && (wr_cnt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (sof_abort && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule
